// File: rtl/pingpong_transposer_pkg.sv
// Shared types and constants for the ping-pong block transposer.
package systolic_pkg;

  localparam int unsigned ELEM_W = 16;
  localparam int unsigned N      = 4;
  localparam int unsigned IDX_W  = $clog2(N);

  typedef logic [ELEM_W-1:0] elem_t;
  typedef elem_t [N-1:0]     row_t;
  typedef logic [IDX_W-1:0]  idx_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam idx_t IDX_LAST = idx_t'(N - 1);

endpackage

// File: rtl/pingpong_transposer_if.sv
// Row-in / column-out valid-ready streams of the transposer.
interface pingpong_transposer_if;
  import systolic_pkg::*;

  logic in_valid;
  logic in_ready;
  row_t in_data;
  logic out_valid;
  logic out_ready;
  row_t out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pingpong_transposer_bank.sv
// One NxN transpose bank: row write port, combinational column read, full/dir flags.
module transpose_bank
  import systolic_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic wr_en,
  input  idx_t wr_row,
  input  row_t wr_data,
  input  logic set_full,
  input  dir_e dir,
  input  logic clr_full,
  input  idx_t rd_col,
  input  logic rd_rev,
  output row_t rd_data,
  output logic full,
  output dir_e dir_q
);

  row_t mem [N];
  logic full_q;

  // Storage needs no reset: it is only read while the bank is marked full.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      dir_q  <= DIR_UP;
    end else if (clear) begin
      full_q <= 1'b0;
    end else if (set_full) begin
      full_q <= 1'b1;
      dir_q  <= dir;
    end else if (clr_full) begin
      full_q <= 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int j = 0; j < N; j++) begin
      rd_data[j] = mem[rd_rev ? idx_t'(N - 1 - j) : idx_t'(j)][rd_col];
    end
  end

  assign full = full_q;

endmodule

// File: rtl/pingpong_transposer.sv
// Ping-pong 4x4 transposer: one bank fills with rows while the other drains columns.
module pingpong_transposer
  import systolic_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic dir,
  output logic rd_bank,
  output logic busy,
  pingpong_transposer_if.slave bus
);

  logic wr_bank_q, wr_bank_d;
  logic rd_bank_q, rd_bank_d;
  idx_t wr_row_q, wr_row_d;
  idx_t rd_col_q, rd_col_d;
  row_t out_data_q, out_data_d;

  logic accept, wr_last, col_done, rd_last, swap, rd_full_nxt;
  logic [1:0] full, wr_en, set_full, clr_full, rd_rev;
  dir_e bank_dir [2];
  row_t bank_col [2];
  dir_e dir_in;

  assign dir_in = dir_e'(dir);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    transpose_bank u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .wr_en    (wr_en[b]),
      .wr_row   (wr_row_q),
      .wr_data  (bus.in_data),
      .set_full (set_full[b]),
      .dir      (dir_in),
      .clr_full (clr_full[b]),
      .rd_col   (rd_col_d),
      .rd_rev   (rd_rev[b]),
      .rd_data  (bank_col[b]),
      .full     (full[b]),
      .dir_q    (bank_dir[b])
    );
  end

  assign bus.in_ready  = !full[wr_bank_q];
  assign bus.out_valid = full[rd_bank_q];
  assign bus.out_data  = out_data_q;
  assign rd_bank       = rd_bank_q;
  assign busy          = (|full) || (wr_row_q != '0);

  always_comb begin
    accept   = bus.in_valid && bus.in_ready;
    wr_last  = accept && (wr_row_q == IDX_LAST);
    col_done = bus.out_valid && bus.out_ready;
    rd_last  = col_done && (rd_col_q == IDX_LAST);
    // Swap on the edge that fills the write bank, so streaming never stalls in_ready.
    swap     = (full[wr_bank_q] || wr_last) && (!full[rd_bank_q] || rd_last);

    wr_row_d    = accept ? ((wr_row_q == IDX_LAST) ? '0 : wr_row_q + 1'b1) : wr_row_q;
    rd_col_d    = col_done ? ((rd_col_q == IDX_LAST) ? '0 : rd_col_q + 1'b1) : rd_col_q;
    wr_bank_d   = wr_bank_q ^ swap;
    rd_bank_d   = rd_bank_q ^ swap;
    rd_full_nxt = swap || (full[rd_bank_q] && !rd_last);

    for (int b = 0; b < 2; b++) begin
      wr_en[b]    = accept && (wr_bank_q == 1'(b));
      set_full[b] = wr_last && (wr_bank_q == 1'(b));
      clr_full[b] = rd_last && (rd_bank_q == 1'(b));
      // A bank latching its dir this edge is read with the incoming dir.
      rd_rev[b]   = set_full[b] ? (dir_in == DIR_UP) : (bank_dir[b] == DIR_UP);
    end

    if (clear) begin
      wr_row_d  = '0;
      rd_col_d  = '0;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b1;
    end
  end

  always_comb begin
    out_data_d = '0;
    if (rd_full_nxt && !clear) begin
      out_data_d = bank_col[rd_bank_d];
      // Last row is still on in_data when the freshly filled bank starts draining.
      if (swap && wr_last) begin
        out_data_d[(dir_in == DIR_UP) ? idx_t'(0) : IDX_LAST] = bus.in_data[rd_col_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b1;
      wr_row_q   <= '0;
      rd_col_q   <= '0;
      out_data_q <= '0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_row_q   <= wr_row_d;
      rd_col_q   <= rd_col_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_pingpong_transposer.sv
// Scoreboard bench for pingpong_transposer: directed scenarios plus a random soak.
module tb_pingpong_transposer;
  import systolic_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;
  logic dir = 1'b0;
  logic rd_bank, busy;

  pingpong_transposer_if bus ();

  pingpong_transposer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .dir     (dir),
    .rd_bank (rd_bank),
    .busy    (busy),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  row_t exp_q [$];
  row_t part  [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic row_t spec_row(input int r);
    row_t x;
    for (int c = 0; c < N; c++) x[c] = elem_t'(4 * r + c);
    return x;
  endfunction

  function automatic row_t rand_row();
    row_t x;
    for (int c = 0; c < N; c++) x[c] = elem_t'($urandom);
    return x;
  endfunction

  // Reference model: collect accepted rows; a complete block yields N expected columns.
  always @(negedge clk) begin
    row_t col;
    if (!rst_n || clear) begin
      part.delete();
      exp_q.delete();
    end else if (bus.in_valid && bus.in_ready) begin
      part.push_back(bus.in_data);
      if (part.size() == N) begin
        for (int k = 0; k < N; k++) begin
          for (int j = 0; j < N; j++) begin
            col[j] = dir ? part[j][k] : part[N - 1 - j][k];
          end
          exp_q.push_back(col);
        end
        part.delete();
      end
    end
  end

  // Output monitor: every presented column must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && !clear && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_column: got %h, expected no valid column", bus.out_data);
      end else begin
        check("sb_out_data", bus.out_data, exp_q[0]);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input row_t r);
    bit done;
    int waited;
    done = 1'b0;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = r;
    while (!done) begin
      @(negedge clk);
      done = bus.in_ready;
      cycle();
      waited++;
      if (!done && waited > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_row_timeout: in_ready low for %0d cycles, expected 1", waited);
        done = 1'b1;
      end
    end
  endtask

  task automatic drain_count(input int budget, output int cnt);
    cnt = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) cnt++;
      if (!busy) break;
      cycle();
    end
    cycle();
  endtask

  initial begin
    int drops, cnt;
    logic [12:0] ov_v, ov_exp, rb_v, rb_exp;
    logic [8:0] ir_v, ir_exp;
    logic d0, d1;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #2;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_bank", rd_bank, 1);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // T1: push down, first column one cycle after row 3
    dir = 1'b1;
    bus.out_ready = 1'b1;
    for (int r = 0; r < N; r++) send_row(spec_row(r));
    bus.in_valid = 1'b0;
    check("t1_out_valid", bus.out_valid, 1);
    check("t1_col0", bus.out_data, 64'h000C_0008_0004_0000);
    check("t1_rd_bank", rd_bank, 0);
    repeat (3) cycle();
    check("t1_col3", bus.out_data, 64'h000F_000B_0007_0003);
    cycle();
    check("t1_valid_after", bus.out_valid, 0);
    check("t1_busy_after", busy, 0);

    // T2: push up
    dir = 1'b0;
    for (int r = 0; r < N; r++) send_row(spec_row(r));
    bus.in_valid = 1'b0;
    check("t2_col0", bus.out_data, 64'h0000_0004_0008_000C);
    repeat (4) cycle();

    // T3: streaming two blocks back to back
    d0 = 1'($urandom);
    d1 = 1'($urandom);
    drops = 0;
    for (int c = 0; c < 13; c++) begin
      bus.in_valid = (c < 8);
      if (c < 8) begin
        dir = (c < 4) ? d0 : d1;
        bus.in_data = rand_row();
      end
      @(negedge clk);
      if (c < 8 && !bus.in_ready) drops++;
      ov_v[c]   = bus.out_valid;
      rb_v[c]   = rd_bank;
      ov_exp[c] = (c >= 4 && c < 12);
      rb_exp[c] = !(c >= 4 && c < 8);
      cycle();
    end
    check("t3_in_ready_drops", drops, 0);
    check("t3_out_valid_pattern", ov_v, ov_exp);
    check("t3_rd_bank_pattern", rb_v, rb_exp);

    // T4: backpressure while 8 rows are offered
    bus.out_ready = 1'b0;
    for (int c = 0; c < 9; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = rand_row();
      dir = 1'($urandom);
      @(negedge clk);
      ir_v[c]   = bus.in_ready;
      ir_exp[c] = (c < 8);
      if (c == 8) check("t4_out_valid_held", bus.out_valid, 1);
      cycle();
    end
    check("t4_in_ready_pattern", ir_v, ir_exp);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain_count(30, cnt);
    check("t4_drained_columns", cnt, 8);

    // T5: clear mid-block
    dir = 1'($urandom);
    send_row(rand_row());
    send_row(rand_row());
    bus.in_valid = 1'b0;
    check("t5_busy_partial", busy, 1);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check("t5_busy_cleared", busy, 0);
    check("t5_out_valid_cleared", bus.out_valid, 0);
    check("t5_in_ready_cleared", bus.in_ready, 1);
    for (int r = 0; r < N; r++) send_row(rand_row());
    bus.in_valid = 1'b0;
    drain_count(20, cnt);
    check("t5_clean_block_columns", cnt, 4);

    // T6: reset while column 1 is presented
    for (int r = 0; r < N; r++) send_row(rand_row());
    bus.in_valid = 1'b0;
    cycle();
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_out_data", bus.out_data, 0);
    check("t6_in_ready", bus.in_ready, 1);
    check("t6_busy", busy, 0);
    cycle();
    rst_n = 1'b1;
    cycle();

    // Random soak: gaps, backpressure and dir changes mid-block
    for (int c = 0; c < 200; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = rand_row();
      bus.out_ready = ($urandom_range(0, 2) != 0);
      dir = 1'($urandom);
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (12) cycle();
    check("soak_all_columns_drained", exp_q.size(), 0);
    check("soak_out_valid_idle", bus.out_valid, 0);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
